// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the gp_cpu decode stage.
//   - opcode constants for instr[15:11]
//   - dispatch FSM state and accelerator-kind enums
//   - IdEx control bundle and its opcode decoder
package cpu_pkg;

   localparam int DW   = 16;
   localparam int NREG = 8;

   localparam logic [4:0] OP_ALU  = 5'h00;
   localparam logic [4:0] OP_ADDI = 5'h01;
   localparam logic [4:0] OP_LW   = 5'h02;
   localparam logic [4:0] OP_SW   = 5'h03;
   localparam logic [4:0] OP_BEQ  = 5'h04;
   localparam logic [4:0] OP_JMP  = 5'h05;
   localparam logic [4:0] OP_HASH = 5'h10;
   localparam logic [4:0] OP_ENC  = 5'h11;
   localparam logic [4:0] OP_DEC  = 5'h12;
   localparam logic [4:0] OP_HALT = 5'h1F;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_HALTED  = 2'd3
   } dispState_t;

   typedef enum logic [1:0] {
      ACC_HASH = 2'd0,
      ACC_ENC  = 2'd1,
      ACC_DEC  = 2'd2
   } accKind_t;

   typedef struct packed {
      logic memRead;
      logic memWrite;
      logic memToReg;
      logic aluSrc;
      logic regWrite;
   } ctrl_t;

   // Anything not listed (branches, accelerator ops, HALT, undefined) is a NOP.
   function automatic ctrl_t decodeCtrl(input logic [4:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_ALU:  c.regWrite = 1'b1;
         OP_ADDI: begin c.regWrite = 1'b1; c.aluSrc = 1'b1; end
         OP_LW:   begin c.memRead = 1'b1; c.memToReg = 1'b1; c.regWrite = 1'b1; c.aluSrc = 1'b1; end
         OP_SW:   begin c.memWrite = 1'b1; c.aluSrc = 1'b1; end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: NREG x DW register file, two read ports, one write port.
//   clk, rst           clock, async active-high reset (clears all entries)
//   rdAddr1/2, rdData1/2  combinational read ports
//   wrEn, wrAddr, wrData  write port, committed at posedge
// r0 reads as 0 and ignores writes. A read of the register being written in
// the same cycle returns wrData so decode never sees a stale operand from WB.
module reg_file
   import cpu_pkg::*;
#(
   parameter int  DW   = cpu_pkg::DW,
   parameter int  NREG = cpu_pkg::NREG,
   localparam int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] rdAddr1,
   input  logic [AW-1:0] rdAddr2,
   input  logic          wrEn,
   input  logic [AW-1:0] wrAddr,
   input  logic [DW-1:0] wrData,
   output logic [DW-1:0] rdData1,
   output logic [DW-1:0] rdData2
);

   logic [DW-1:0] regs [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wrEn && (wrAddr != '0)) begin
         regs[wrAddr] <= wrData;
      end
   end

   always_comb begin
      rdData1 = regs[rdAddr1];
      if (rdAddr1 == '0)                    rdData1 = '0;
      else if (wrEn && (wrAddr == rdAddr1)) rdData1 = wrData;
   end

   always_comb begin
      rdData2 = regs[rdAddr2];
      if (rdAddr2 == '0)                    rdData2 = '0;
      else if (wrEn && (wrAddr == rdAddr2)) rdData2 = wrData;
   end

endmodule

// File: rtl/id_stage.sv
// id_stage: decode stage of the gp_cpu pipeline (between IfId and IdEx).
//   instr, pc                  IfId contents
//   wb_en, wb_rd, wb_data      register write-back from MemWb
//   idex_*/exmem_*             pending writes used for RAW stall detection
//   H/E/D_done                 accelerator completion pulses
//   read_data1/2, imm, control outputs, rd, opcode, aluOp -> IdEx
//   stall, branch, target_pc   fetch control
//   H/E/D_int, index           accelerator start pulses and job index
//   cpu_done                   sticky halt flag
//
// Dispatch FSM
//   state      | meaning
//   IDLE       | normal decode; may issue an accelerator op or HALT
//   WAIT       | accelerator running; stall until the matching done
//   RELEASE    | one cycle letting the accelerator op leave IfId as a NOP
//   HALTED     | HALT retired; stall forever until reset
module id_stage
   import cpu_pkg::*;
#(
   parameter int DW   = cpu_pkg::DW,
   parameter int NREG = cpu_pkg::NREG
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   instr,
   input  logic [DW-1:0] pc,
   input  logic          wb_en,
   input  logic [2:0]    wb_rd,
   input  logic [DW-1:0] wb_data,
   input  logic          idex_regWrite,
   input  logic [2:0]    idex_rd,
   input  logic          exmem_regWrite,
   input  logic [2:0]    exmem_rd,
   input  logic          H_done,
   input  logic          E_done,
   input  logic          D_done,
   output logic [DW-1:0] read_data1,
   output logic [DW-1:0] read_data2,
   output logic [DW-1:0] imm,
   output logic          memRead,
   output logic          memWrite,
   output logic          memToReg,
   output logic          aluSrc,
   output logic          regWrite,
   output logic [1:0]    aluOp,
   output logic [2:0]    rd,
   output logic [4:0]    opcode,
   output logic          stall,
   output logic          branch,
   output logic [DW-1:0] target_pc,
   output logic          H_int,
   output logic          E_int,
   output logic          D_int,
   output logic [10:0]   index,
   output logic          cpu_done
);

   logic [2:0] rsF, rtF, addr2;
   logic       usesRs, usesP2, haz, isAcc, isHalt, branchTaken, issue, doneMatch;
   ctrl_t      ctrl;
   accKind_t   accKind, newKind;
   dispState_t state, nextState;

   assign opcode = instr[15:11];
   assign rd     = instr[10:8];
   assign rsF    = instr[7:5];
   assign rtF    = instr[4:2];
   assign aluOp  = instr[1:0];
   assign imm    = {{(DW-5){instr[4]}}, instr[4:0]};

   // SW stores reg[rd] and BEQ compares against reg[rd], so port 2 follows rd there.
   assign addr2  = ((opcode == OP_SW) || (opcode == OP_BEQ)) ? rd : rtF;

   reg_file #(.DW(DW), .NREG(NREG)) u_regFile (
      .clk     (clk),
      .rst     (rst),
      .rdAddr1 (rsF),
      .rdAddr2 (addr2),
      .wrEn    (wb_en),
      .wrAddr  (wb_rd),
      .wrData  (wb_data),
      .rdData1 (read_data1),
      .rdData2 (read_data2)
   );

   assign usesRs = (opcode == OP_ALU) || (opcode == OP_ADDI) || (opcode == OP_LW) ||
                   (opcode == OP_SW)  || (opcode == OP_BEQ);
   assign usesP2 = (opcode == OP_ALU) || (opcode == OP_SW) || (opcode == OP_BEQ);

   function automatic logic pending(input logic [2:0] a);
      return (a != 3'd0) && ((idex_regWrite && (idex_rd == a)) ||
                             (exmem_regWrite && (exmem_rd == a)));
   endfunction

   assign haz    = (usesRs && pending(rsF)) || (usesP2 && pending(addr2));
   assign isAcc  = (opcode == OP_HASH) || (opcode == OP_ENC) || (opcode == OP_DEC);
   assign isHalt = (opcode == OP_HALT);

   assign target_pc   = (opcode == OP_JMP) ? pc + {{(DW-11){instr[10]}}, instr[10:0]}
                                           : pc + imm;
   assign branchTaken = (opcode == OP_JMP) ||
                        ((opcode == OP_BEQ) && (read_data1 == read_data2));

   always_comb begin
      newKind = ACC_HASH;
      if (opcode == OP_ENC)      newKind = ACC_ENC;
      else if (opcode == OP_DEC) newKind = ACC_DEC;
   end

   always_comb begin
      doneMatch = 1'b0;
      case (accKind)
         ACC_HASH: doneMatch = H_done;
         ACC_ENC:  doneMatch = E_done;
         ACC_DEC:  doneMatch = D_done;
         default:  doneMatch = 1'b0;
      endcase
   end

   always_comb begin
      nextState = state;
      stall     = 1'b0;
      branch    = 1'b0;
      issue     = 1'b0;
      ctrl      = decodeCtrl(opcode);
      case (state)
         ST_HALTED: begin
            stall = 1'b1;
            ctrl  = '0;
         end
         ST_WAIT: begin
            stall = 1'b1;
            ctrl  = '0;
            if (doneMatch) nextState = ST_RELEASE;
         end
         ST_RELEASE: begin
            ctrl      = '0;
            nextState = ST_IDLE;
         end
         default: begin
            if (haz) begin
               stall = 1'b1;
               ctrl  = '0;
            end else if (isAcc) begin
               stall     = 1'b1;
               issue     = 1'b1;
               nextState = ST_WAIT;
            end else if (isHalt) begin
               // Hold HALT in IfId; HALTED keeps the stall afterwards.
               stall     = 1'b1;
               nextState = ST_HALTED;
            end else begin
               branch = branchTaken;
            end
         end
      endcase
   end

   assign memRead  = ctrl.memRead;
   assign memWrite = ctrl.memWrite;
   assign memToReg = ctrl.memToReg;
   assign aluSrc   = ctrl.aluSrc;
   assign regWrite = ctrl.regWrite;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         accKind  <= ACC_HASH;
         H_int    <= 1'b0;
         E_int    <= 1'b0;
         D_int    <= 1'b0;
         index    <= '0;
         cpu_done <= 1'b0;
      end else begin
         state <= nextState;
         H_int <= 1'b0;
         E_int <= 1'b0;
         D_int <= 1'b0;
         if (issue) begin
            index   <= instr[10:0];
            accKind <= newKind;
            H_int   <= (newKind == ACC_HASH);
            E_int   <= (newKind == ACC_ENC);
            D_int   <= (newKind == ACC_DEC);
         end
         if ((state == ST_IDLE) && (nextState == ST_HALTED)) cpu_done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr, pc, wb_data;
   logic        wb_en, idex_regWrite, exmem_regWrite;
   logic [2:0]  wb_rd, idex_rd, exmem_rd;
   logic        H_done, E_done, D_done;
   logic [15:0] read_data1, read_data2, imm, target_pc;
   logic        memRead, memWrite, memToReg, aluSrc, regWrite;
   logic [1:0]  aluOp;
   logic [2:0]  rd;
   logic [4:0]  opcode;
   logic        stall, branch, H_int, E_int, D_int, cpu_done;
   logic [10:0] index;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_stage dut (
      .clk(clk), .rst(rst), .instr(instr), .pc(pc),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .idex_regWrite(idex_regWrite), .idex_rd(idex_rd),
      .exmem_regWrite(exmem_regWrite), .exmem_rd(exmem_rd),
      .H_done(H_done), .E_done(E_done), .D_done(D_done),
      .read_data1(read_data1), .read_data2(read_data2), .imm(imm),
      .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
      .aluSrc(aluSrc), .regWrite(regWrite), .aluOp(aluOp), .rd(rd),
      .opcode(opcode), .stall(stall), .branch(branch), .target_pc(target_pc),
      .H_int(H_int), .E_int(E_int), .D_int(D_int), .index(index),
      .cpu_done(cpu_done)
   );

   logic [4:0] ctrlV;
   assign ctrlV = {memRead, memWrite, memToReg, aluSrc, regWrite};

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
      logic        idexW;
      logic [2:0]  idexRd;
      logic        exW;
      logic [2:0]  exRd;
      logic        expStall;
      logic        expBranch;
      logic [4:0]  expCtrl;
      logic        chkTarget;
      logic [15:0] expTarget;
   } vec_t;

   typedef struct {
      int          id;
      logic        expStall;
      logic        expBranch;
      logic [4:0]  expCtrl;
      logic        chkTarget;
      logic [15:0] expTarget;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[19];

   function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [2:0] c,
                                      input logic [1:0] lo);
      return {op, a, b, c, lo};
   endfunction

   function automatic vec_t mkv(input logic [15:0] i, input logic [15:0] p,
                                input logic iw, input logic [2:0] ir,
                                input logic ew, input logic [2:0] er,
                                input logic s, input logic b, input logic [4:0] c,
                                input logic ct, input logic [15:0] t);
      vec_t v;
      v.instr = i; v.pc = p; v.idexW = iw; v.idexRd = ir; v.exW = ew; v.exRd = er;
      v.expStall = s; v.expBranch = b; v.expCtrl = c; v.chkTarget = ct; v.expTarget = t;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wbWrite(input logic [2:0] a, input logic [15:0] d);
      wb_en = 1'b1; wb_rd = a; wb_data = d;
      step();
      wb_en = 1'b0;
   endtask

   initial begin
      exp_t e;
      rst = 1'b1; instr = '0; pc = '0; wb_en = 0; wb_rd = '0; wb_data = '0;
      idex_regWrite = 0; idex_rd = '0; exmem_regWrite = 0; exmem_rd = '0;
      H_done = 0; E_done = 0; D_done = 0;

      // register state: r1 = 5, r2 = 5, r4 = 6
      vecs[0]  = mkv(mk(OP_ALU, 5,1,2,0), 16'h0000, 0,0, 0,0, 0,0,5'b00001, 0,16'h0);
      vecs[1]  = mkv(mk(OP_ADDI,5,1,3,1), 16'h0000, 0,0, 0,0, 0,0,5'b00011, 0,16'h0);
      vecs[2]  = mkv(mk(OP_LW,  6,1,0,0), 16'h0000, 0,0, 0,0, 0,0,5'b10111, 0,16'h0);
      vecs[3]  = mkv(mk(OP_SW,  2,1,0,1), 16'h0000, 0,0, 0,0, 0,0,5'b01010, 0,16'h0);
      vecs[4]  = mkv(mk(OP_BEQ, 2,1,7,2), 16'h0010, 0,0, 0,0, 0,1,5'b00000, 1,16'h000E);
      vecs[5]  = mkv(mk(OP_BEQ, 4,1,7,2), 16'h0010, 0,0, 0,0, 0,0,5'b00000, 1,16'h000E);
      vecs[6]  = mkv(mk(OP_JMP, 7,7,4,0), 16'h0100, 0,0, 0,0, 0,1,5'b00000, 1,16'h00F0);
      vecs[7]  = mkv(mk(OP_JMP, 0,0,0,2), 16'hFFFF, 0,0, 0,0, 0,1,5'b00000, 1,16'h0001);
      vecs[8]  = mkv(mk(OP_ALU, 5,1,2,0), 16'h0000, 1,2, 0,0, 1,0,5'b00000, 0,16'h0);
      vecs[9]  = mkv(mk(OP_ALU, 5,1,2,0), 16'h0000, 1,0, 0,0, 0,0,5'b00001, 0,16'h0);
      vecs[10] = mkv(mk(OP_LW,  6,3,0,0), 16'h0000, 0,0, 1,3, 1,0,5'b00000, 0,16'h0);
      vecs[11] = mkv(mk(OP_ALU, 5,3,0,0), 16'h0000, 0,3, 0,0, 0,0,5'b00001, 0,16'h0);
      vecs[12] = mkv(mk(OP_ADDI,5,1,2,0), 16'h0000, 1,2, 0,0, 0,0,5'b00011, 0,16'h0);
      vecs[13] = mkv(mk(OP_BEQ, 2,1,7,2), 16'h0010, 1,2, 0,0, 1,0,5'b00000, 0,16'h0);
      vecs[14] = mkv(mk(5'h08,  1,1,1,1), 16'h0000, 0,0, 0,0, 0,0,5'b00000, 0,16'h0);
      vecs[15] = mkv(16'h0000,            16'h0000, 0,0, 0,0, 0,0,5'b00001, 0,16'h0);
      vecs[16] = mkv(mk(OP_SW,  6,0,0,0), 16'h0000, 0,0, 1,6, 1,0,5'b00000, 0,16'h0);
      vecs[17] = mkv(mk(OP_JMP, 0,0,0,2), 16'hFFFF, 1,7, 0,0, 0,1,5'b00000, 1,16'h0001);
      vecs[18] = mkv(mk(OP_BEQ, 2,1,7,2), 16'h0010, 0,0, 1,1, 1,0,5'b00000, 0,16'h0);

      // reset state
      step(); step();
      @(negedge clk);
      chk("reset_cpu_done", 32'(cpu_done), 32'(0));
      chk("reset_index",    32'(index),    32'(0));
      chk("reset_ints",     32'({H_int, E_int, D_int}), 32'(0));
      chk("reset_stall",    32'(stall),    32'(0));
      chk("reset_rd1",      32'(read_data1), 32'(0));
      step();
      rst = 1'b0;

      // write-through bypass, then the stored value, then r0 stays 0
      wb_en = 1; wb_rd = 3; wb_data = 16'h1234; instr = mk(OP_ALU, 5,3,0,0);
      @(negedge clk);
      chk("bypass_rd1", 32'(read_data1), 32'(16'h1234));
      step();
      wb_en = 0;
      @(negedge clk);
      chk("stored_rd1", 32'(read_data1), 32'(16'h1234));
      step();
      wb_en = 1; wb_rd = 0; wb_data = 16'hFFFF; instr = mk(OP_ALU, 0,0,0,0);
      @(negedge clk);
      chk("r0_bypass", 32'(read_data1), 32'(0));
      step();
      wb_en = 0;
      @(negedge clk);
      chk("r0_write", 32'(read_data2), 32'(0));
      step();

      wbWrite(3'd1, 16'd5);
      wbWrite(3'd2, 16'd5);
      wbWrite(3'd4, 16'd6);

      // table vectors through the scoreboard
      for (int i = 0; i < 19; i++) begin
         instr = vecs[i].instr; pc = vecs[i].pc;
         idex_regWrite = vecs[i].idexW; idex_rd = vecs[i].idexRd;
         exmem_regWrite = vecs[i].exW;  exmem_rd = vecs[i].exRd;
         e.id = i; e.expStall = vecs[i].expStall; e.expBranch = vecs[i].expBranch;
         e.expCtrl = vecs[i].expCtrl; e.chkTarget = vecs[i].chkTarget;
         e.expTarget = vecs[i].expTarget;
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         chk($sformatf("vec%0d_stall", e.id),  32'(stall),  32'(e.expStall));
         chk($sformatf("vec%0d_branch", e.id), 32'(branch), 32'(e.expBranch));
         chk($sformatf("vec%0d_ctrl", e.id),   32'(ctrlV),  32'(e.expCtrl));
         if (e.chkTarget) chk($sformatf("vec%0d_target", e.id), 32'(target_pc), 32'(e.expTarget));
         step();
      end
      idex_regWrite = 0; idex_rd = '0; exmem_regWrite = 0; exmem_rd = '0; pc = '0;

      // HASH dispatch; wrong done ignored; one RELEASE cycle
      instr = {OP_HASH, 11'h2A5};
      @(negedge clk);
      chk("hash_issue_stall", 32'(stall), 32'(1));
      chk("hash_issue_hint",  32'(H_int), 32'(0));
      step();
      @(negedge clk);
      chk("hash_hint",  32'(H_int), 32'(1));
      chk("hash_index", 32'(index), 32'(11'h2A5));
      chk("hash_stall", 32'(stall), 32'(1));
      chk("hash_eint",  32'(E_int), 32'(0));
      step();
      E_done = 1;
      @(negedge clk);
      chk("hash_hint_once", 32'(H_int), 32'(0));
      chk("hash_wait_stall", 32'(stall), 32'(1));
      step();
      E_done = 0;
      @(negedge clk);
      chk("hash_edone_ignored", 32'(stall), 32'(1));
      step();
      H_done = 1;
      @(negedge clk);
      chk("hash_done_cycle_stall", 32'(stall), 32'(1));
      step();
      H_done = 0;
      @(negedge clk);
      chk("hash_release_stall", 32'(stall), 32'(0));
      chk("hash_release_ctrl",  32'(ctrlV), 32'(0));
      step();
      instr = mk(OP_ALU, 5,1,2,0); D_done = 1;
      @(negedge clk);
      chk("idle_after_release_stall", 32'(stall), 32'(0));
      chk("idle_after_release_ctrl",  32'(ctrlV), 32'(5'b00001));
      chk("idle_no_int", 32'({H_int, E_int, D_int}), 32'(0));
      step();
      D_done = 0;
      @(negedge clk);
      chk("idle_done_ignored", 32'(stall), 32'(0));
      step();

      // ENC with reset mid-WAIT, then re-issue
      instr = {OP_ENC, 11'h155};
      @(negedge clk);
      chk("enc_issue_stall", 32'(stall), 32'(1));
      step();
      @(negedge clk);
      chk("enc_eint",  32'(E_int), 32'(1));
      chk("enc_hint",  32'(H_int), 32'(0));
      chk("enc_index", 32'(index), 32'(11'h155));
      step();
      rst = 1; instr = '0;
      @(negedge clk);
      chk("enc_rst_eint",  32'(E_int), 32'(0));
      chk("enc_rst_index", 32'(index), 32'(0));
      chk("enc_rst_stall", 32'(stall), 32'(0));
      step();
      rst = 0; instr = {OP_ENC, 11'h0AA};
      @(negedge clk);
      chk("enc2_issue_stall", 32'(stall), 32'(1));
      chk("enc2_eint_pre",    32'(E_int), 32'(0));
      step();
      @(negedge clk);
      chk("enc2_eint",  32'(E_int), 32'(1));
      chk("enc2_index", 32'(index), 32'(11'h0AA));
      step();
      E_done = 1;
      step();
      E_done = 0;
      @(negedge clk);
      chk("enc2_release_stall", 32'(stall), 32'(0));
      step();
      instr = '0;

      // HALT: sticky until reset
      instr = {OP_HALT, 11'h0};
      @(negedge clk);
      chk("halt_issue_stall", 32'(stall),    32'(1));
      chk("halt_issue_done",  32'(cpu_done), 32'(0));
      step();
      instr = mk(OP_ALU, 5,1,2,0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk($sformatf("halted%0d_done", c),  32'(cpu_done), 32'(1));
         chk($sformatf("halted%0d_stall", c), 32'(stall),    32'(1));
         chk($sformatf("halted%0d_ctrl", c),  32'(ctrlV),    32'(0));
         step();
      end
      rst = 1;
      @(negedge clk);
      chk("halt_rst_done",  32'(cpu_done), 32'(0));
      chk("halt_rst_stall", 32'(stall),    32'(0));
      step();
      rst = 0;
      @(negedge clk);
      chk("after_halt_ctrl", 32'(ctrlV), 32'(5'b00001));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
